// File: rtl/guess_engine.sv
// guess_engine: per-round hangman guess checker.
// Loads a 6-letter word plus hint mask, accepts one guess at a time over a
// valid/ready handshake, scans the word one position per cycle, and reports
// hit/miss/dup/bad pulses, wrong-guess count and win/lost levels.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   load              one-cycle pulse: sample word/mask, start a new round
//   word[29:0]        six 5-bit letter codes, position i = word[5i+4:5i]
//   mask[25:0]        hint letters, bit k-1 = letter code k pre-revealed
//   guess_valid       guess offered
//   guess_letter[4:0] guessed letter code
//   guess_ready       engine accepts a guess
//   revealed[5:0]     bit i = position i shown
//   guessed[25:0]     letters already used (hints included)
//   wrong_count[3:0]  wrong guesses so far
//   hit/miss/dup/bad  one-cycle result pulses
//   win_game/lost_game round-over levels
module guess_engine #(
    parameter int unsigned MAX_WRONG = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [29:0] word,
    input  logic [25:0] mask,
    input  logic        guess_valid,
    input  logic [4:0]  guess_letter,
    output logic        guess_ready,
    output logic [5:0]  revealed,
    output logic [25:0] guessed,
    output logic [3:0]  wrong_count,
    output logic        hit,
    output logic        miss,
    output logic        dup,
    output logic        bad,
    output logic        win_game,
    output logic        lost_game
);

    localparam int unsigned N_POS   = 6;
    localparam int unsigned CODE_W  = 5;
    localparam int unsigned N_LET   = 26;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned WC_W    = 4;
    localparam logic [WC_W-1:0] MAX_W = WC_W'(MAX_WRONG);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_READY, S_SCAN, S_RESULT, S_WIN, S_LOST
    } state_t;

    // Which kind of result the RESULT state has to report.
    typedef enum logic [1:0] {
        R_SCAN, R_BAD, R_DUP
    } res_t;

    state_t                     state_q;
    res_t                       res_q;
    logic [N_POS*CODE_W-1:0]    word_q;
    logic [CODE_W-1:0]          letter_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       match_q;

    logic [N_POS-1:0]           load_reveal_c;
    logic [CODE_W-1:0]          cur_code_c;
    logic [N_LET-1:0]           guess_hot_c;
    logic [WC_W-1:0]            wrong_inc_c;

    // Codes 1..26 are letters; 0 and 27..31 are blanks / illegal guesses.
    function automatic logic is_letter(input logic [CODE_W-1:0] code);
        return (code >= CODE_W'(1)) && (code <= CODE_W'(N_LET));
    endfunction

    function automatic logic [N_LET-1:0] letter_onehot(input logic [CODE_W-1:0] code);
        return is_letter(code) ? (N_LET'(1) << (code - CODE_W'(1))) : '0;
    endfunction

    // Initial reveal vector and current scan letter from the latched word.
    always_comb begin
        load_reveal_c = '0;
        cur_code_c    = '0;
        for (int i = 0; i < N_POS; i++) begin
            if (is_letter(word_q[i*CODE_W +: CODE_W]))
                load_reveal_c[i] = guessed[word_q[i*CODE_W +: CODE_W] - CODE_W'(1)];
            else
                load_reveal_c[i] = 1'b1;
            if (idx_q == IDX_W'(i))
                cur_code_c = word_q[i*CODE_W +: CODE_W];
        end
    end

    assign guess_hot_c = letter_onehot(guess_letter);
    assign wrong_inc_c = (wrong_count < MAX_W) ? wrong_count + WC_W'(1) : wrong_count;

    // Round FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            res_q       <= R_SCAN;
            word_q      <= '0;
            letter_q    <= '0;
            idx_q       <= '0;
            match_q     <= 1'b0;
            guess_ready <= 1'b0;
            revealed    <= '0;
            guessed     <= '0;
            wrong_count <= '0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            dup         <= 1'b0;
            bad         <= 1'b0;
            win_game    <= 1'b0;
            lost_game   <= 1'b0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            dup  <= 1'b0;
            bad  <= 1'b0;
            if (load) begin
                // load overrides everything, including a coincident handshake
                state_q     <= S_LOAD;
                word_q      <= word;
                guessed     <= mask;
                revealed    <= '0;
                wrong_count <= '0;
                win_game    <= 1'b0;
                lost_game   <= 1'b0;
                guess_ready <= 1'b0;
                match_q     <= 1'b0;
                idx_q       <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                    end
                    S_LOAD: begin
                        revealed <= load_reveal_c;
                        if (&load_reveal_c) begin
                            state_q  <= S_WIN;
                            win_game <= 1'b1;
                        end else begin
                            state_q     <= S_READY;
                            guess_ready <= 1'b1;
                        end
                    end
                    S_READY: begin
                        if (guess_valid && guess_ready) begin
                            guess_ready <= 1'b0;
                            letter_q    <= guess_letter;
                            if (!is_letter(guess_letter)) begin
                                res_q   <= R_BAD;
                                state_q <= S_RESULT;
                            end else if ((guessed & guess_hot_c) != '0) begin
                                res_q   <= R_DUP;
                                state_q <= S_RESULT;
                            end else begin
                                guessed <= guessed | guess_hot_c;
                                res_q   <= R_SCAN;
                                idx_q   <= '0;
                                match_q <= 1'b0;
                                state_q <= S_SCAN;
                            end
                        end
                    end
                    S_SCAN: begin
                        if (cur_code_c == letter_q) begin
                            revealed[idx_q] <= 1'b1;
                            match_q         <= 1'b1;
                        end
                        if (idx_q == IDX_W'(N_POS - 1))
                            state_q <= S_RESULT;
                        else
                            idx_q <= idx_q + IDX_W'(1);
                    end
                    S_RESULT: begin
                        case (res_q)
                            R_BAD: begin
                                bad         <= 1'b1;
                                guess_ready <= 1'b1;
                                state_q     <= S_READY;
                            end
                            R_DUP: begin
                                dup         <= 1'b1;
                                guess_ready <= 1'b1;
                                state_q     <= S_READY;
                            end
                            default: begin
                                if (match_q) begin
                                    hit <= 1'b1;
                                end else begin
                                    miss        <= 1'b1;
                                    wrong_count <= wrong_inc_c;
                                end
                                if (&revealed) begin
                                    state_q  <= S_WIN;
                                    win_game <= 1'b1;
                                end else if (!match_q && (wrong_inc_c == MAX_W)) begin
                                    state_q   <= S_LOST;
                                    lost_game <= 1'b1;
                                end else begin
                                    state_q     <= S_READY;
                                    guess_ready <= 1'b1;
                                end
                            end
                        endcase
                    end
                    S_WIN, S_LOST: begin
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_engine.sv
// Self-checking bench for guess_engine: directed steps, scoreboard queue of
// expected guess results popped when the result pulse appears.
module tb_guess_engine;

    localparam int unsigned MAXW = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [29:0] word = '0;
    logic [25:0] mask = '0;
    logic        guess_valid = 1'b0;
    logic [4:0]  guess_letter = '0;
    logic        guess_ready;
    logic [5:0]  revealed;
    logic [25:0] guessed;
    logic [3:0]  wrong_count;
    logic        hit, miss, dup, bad, win_game, lost_game;

    guess_engine #(.MAX_WRONG(MAXW)) dut (
        .clk(clk), .reset(reset), .load(load), .word(word), .mask(mask),
        .guess_valid(guess_valid), .guess_letter(guess_letter),
        .guess_ready(guess_ready), .revealed(revealed), .guessed(guessed),
        .wrong_count(wrong_count), .hit(hit), .miss(miss), .dup(dup), .bad(bad),
        .win_game(win_game), .lost_game(lost_game)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  kind;   // {hit, miss, dup, bad}
        int          lat;
        logic [5:0]  rev;
        logic [25:0] gsd;
        logic [3:0]  wc;
        logic        win;
        logic        lost;
        logic        rdy;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;

    logic [29:0] m_word;
    logic [5:0]  m_rev;
    logic [25:0] m_gsd;
    logic [3:0]  m_wc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [29:0] mkword(input int c0, c1, c2, c3, c4, c5);
        return {5'(c5), 5'(c4), 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    endfunction

    function automatic logic [3:0] pulses();
        return {hit, miss, dup, bad};
    endfunction

    // Load a word; model expected reveal from word codes and mask.
    task automatic do_load(input logic [29:0] w, input logic [25:0] m);
        int c;
        @(negedge clk);
        load = 1'b1; word = w; mask = m;
        @(posedge clk); #1;
        load = 1'b0;
        chk("load_edge_ready", 32'(guess_ready), 32'd0);
        m_word = w; m_gsd = m; m_wc = '0; m_rev = '0;
        for (int i = 0; i < 6; i++) begin
            c = int'(w[i*5 +: 5]);
            if (c == 0 || c > 26) m_rev[i] = 1'b1;
            else if (m[c-1]) m_rev[i] = 1'b1;
        end
        @(posedge clk); #1;
        chk("load_revealed", 32'(revealed), 32'(m_rev));
        chk("load_guessed", 32'(guessed), 32'(m_gsd));
        chk("load_wc", 32'(wrong_count), 32'd0);
        chk("load_win", 32'(win_game), 32'(&m_rev));
        chk("load_ready", 32'(guess_ready), 32'(!(&m_rev)));
        chk("load_lost", 32'(lost_game), 32'd0);
    endtask

    task automatic do_guess(input int l);
        exp_t e;
        exp_t g;
        int   cyc;
        bool_wait: begin
            for (int i = 0; i < 50; i++) begin
                if (guess_ready) disable bool_wait;
                @(negedge clk);
            end
        end
        if (!guess_ready) begin
            chk("ready_timeout", 32'(guess_ready), 32'd1);
            return;
        end
        e.lat = 1;
        if (l == 0 || l > 26) begin
            e.kind = 4'b0001;
        end else if (m_gsd[l-1]) begin
            e.kind = 4'b0010;
        end else begin
            logic any;
            any = 1'b0;
            m_gsd[l-1] = 1'b1;
            for (int i = 0; i < 6; i++)
                if (int'(m_word[i*5 +: 5]) == l) begin
                    m_rev[i] = 1'b1;
                    any = 1'b1;
                end
            e.lat = 7;
            if (any) e.kind = 4'b1000;
            else begin
                e.kind = 4'b0100;
                m_wc = m_wc + 4'd1;
            end
        end
        e.rev = m_rev; e.gsd = m_gsd; e.wc = m_wc;
        e.win  = &m_rev;
        e.lost = !(&m_rev) && (m_wc == 4'(MAXW));
        e.rdy  = !(e.win || e.lost);
        sb.push_back(e);
        @(negedge clk);
        guess_valid = 1'b1; guess_letter = 5'(l);
        @(posedge clk); #1;
        guess_valid = 1'b0;
        cyc = 0;
        while (pulses() == 4'b0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        g = sb.pop_front();
        chk("pulse", 32'(pulses()), 32'(g.kind));
        chk("latency", 32'(cyc), 32'(g.lat));
        chk("revealed", 32'(revealed), 32'(g.rev));
        chk("guessed", 32'(guessed), 32'(g.gsd));
        chk("wrong_count", 32'(wrong_count), 32'(g.wc));
        chk("win_game", 32'(win_game), 32'(g.win));
        chk("lost_game", 32'(lost_game), 32'(g.lost));
        chk("guess_ready", 32'(guess_ready), 32'(g.rdy));
        @(posedge clk); #1;
        chk("pulse_one_cycle", 32'(pulses()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {guess_ready, revealed, wrong_count, hit, miss, dup, bad, win_game, lost_game},
            32'd0);
        chk({tag, "_guessed"}, 32'(guessed), 32'd0);
    endtask

    logic [29:0] apple;
    int          npulse;

    initial begin
        apple = mkword(1, 16, 16, 12, 5, 0);
        #3 reset = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle_ready", 32'(guess_ready), 32'd0);

        // Hit then duplicate
        do_load(apple, 26'd0);
        do_guess(16);
        do_guess(16);

        // Six misses -> lost, further guesses ignored
        do_load(apple, 26'd0);
        do_guess(26); do_guess(17); do_guess(24);
        do_guess(10); do_guess(11); do_guess(22);
        npulse = 0;
        @(negedge clk);
        guess_valid = 1'b1; guess_letter = 5'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (pulses() != 4'b0) npulse++;
        end
        guess_valid = 1'b0;
        chk("lost_ignore_pulses", 32'(npulse), 32'd0);
        chk("lost_hold", {wrong_count, lost_game, win_game, guess_ready}, {4'd6, 3'b100});

        // Hint mask A,L,E then P wins
        do_load(apple, (26'd1 << 0) | (26'd1 << 11) | (26'd1 << 4));
        chk("mask_revealed", 32'(revealed), 32'b111001);
        do_guess(16);

        // Bad codes do not count
        do_load(apple, 26'd0);
        do_guess(26);
        do_guess(0);
        do_guess(30);

        // All-ones mask wins on load
        do_load(apple, '1);

        // load during SCAN cycle 3 aborts the guess
        do_load(apple, 26'd0);
        @(negedge clk);
        guess_valid = 1'b1; guess_letter = 5'd26;
        @(posedge clk); #1;
        guess_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        load = 1'b1; word = apple; mask = 26'd0;
        @(posedge clk); #1;
        load = 1'b0;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (pulses() != 4'b0) npulse++;
        end
        chk("abort_pulses", 32'(npulse), 32'd0);
        chk("abort_state", {wrong_count, guess_ready, revealed}, {4'd0, 1'b1, 6'b100000});
        chk("abort_guessed", 32'(guessed), 32'd0);

        // load coincident with handshake drops the guess
        @(negedge clk);
        guess_valid = 1'b1; guess_letter = 5'd16; load = 1'b1;
        @(posedge clk); #1;
        guess_valid = 1'b0; load = 1'b0;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (pulses() != 4'b0) npulse++;
        end
        chk("coincide_pulses", 32'(npulse), 32'd0);
        chk("coincide_state", {guessed, revealed, guess_ready}, {26'd0, 6'b100000, 1'b1});

        // Reset mid-scan clears outputs immediately
        @(negedge clk);
        guess_valid = 1'b1; guess_letter = 5'd16;
        @(posedge clk); #1;
        guess_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge clk) reset = 1'b1;
        guess_valid = 1'b1; guess_letter = 5'd1;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (pulses() != 4'b0 || guess_ready) npulse++;
        end
        guess_valid = 1'b0;
        chk("idle_after_reset", 32'(npulse), 32'd0);
        chk_all_zero("idle_outputs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
